// File: rtl/rv32im_mem_arbiter_pkg.sv
// Shared definitions for the RV32IM core: bus widths, LSU opcodes and
// the memory arbiter's state and owner encodings.
package rv32im_mem_arbiter_pkg;

   localparam int unsigned API_ADDR_WIDTH = 32;
   localparam int unsigned API_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      LSU_OP_NONE  = 2'd0,
      LSU_OP_LOAD  = 2'd1,
      LSU_OP_STORE = 2'd2
   } lsu_op_e;

   typedef enum logic [1:0] {
      ARB_ST_IDLE  = 2'd0,
      ARB_ST_ISSUE = 2'd1,
      ARB_ST_RESP  = 2'd2
   } arb_state_e;

   typedef enum logic {
      ARB_OWN_IF = 1'b0,
      ARB_OWN_LS = 1'b1
   } arb_owner_e;

   // An all-zero byte mask encodes a read.
   function automatic lsu_op_e lsu_op_from_mask(input logic [3:0] mask);
      return (mask == 4'b0000) ? LSU_OP_LOAD : LSU_OP_STORE;
   endfunction

endpackage

// File: rtl/rv32im_mem_arbiter.sv
// Two-requester (IFU/LSU) single-outstanding memory arbiter with
// alternating tie-break and an ack timeout.
module rv32im_mem_arbiter
   import rv32im_mem_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      if_req_i,
   input  logic [API_ADDR_WIDTH-1:0] if_addr_i,
   output logic                      if_gnt_o,
   output logic                      if_rvalid_o,
   output logic [API_DATA_WIDTH-1:0] if_rdata_o,
   output logic                      if_err_o,
   input  logic                      ls_req_i,
   input  logic [API_ADDR_WIDTH-1:0] ls_addr_i,
   input  logic [3:0]                ls_wr_mask_i,
   input  logic [API_DATA_WIDTH-1:0] ls_wdata_i,
   output logic                      ls_gnt_o,
   output logic                      ls_rvalid_o,
   output logic [API_DATA_WIDTH-1:0] ls_rdata_o,
   output logic                      ls_err_o,
   output logic                      mem_req_o,
   output logic [API_ADDR_WIDTH-1:0] mem_addr_o,
   output logic [3:0]                mem_wr_mask_o,
   output logic [API_DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                      mem_ack_i,
   input  logic [API_DATA_WIDTH-1:0] mem_rdata_i
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   arb_state_e                state_q, state_d;
   arb_owner_e                owner_q, owner_d;
   arb_owner_e                last_q,  last_d;
   logic [API_ADDR_WIDTH-1:0] addr_q,  addr_d;
   logic [3:0]                mask_q,  mask_d;
   logic [API_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [API_DATA_WIDTH-1:0] data_q,  data_d;
   logic                      err_q,   err_d;
   logic [CNT_W-1:0]          cnt_q,   cnt_d;
   logic                      pick_ls;
   logic [API_DATA_WIDTH-1:0] resp_data;

   // LSU wins when alone, or on a tie when the IFU was granted last.
   assign pick_ls   = ls_req_i && (!if_req_i || (last_q == ARB_OWN_IF));
   assign resp_data = (lsu_op_from_mask(mask_q) == LSU_OP_STORE) ? '0 : data_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB_ST_IDLE;
         owner_q <= ARB_OWN_IF;
         last_q  <= ARB_OWN_IF;
         addr_q  <= '0;
         mask_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         mask_q  <= mask_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_d        = last_q;
      addr_d        = addr_q;
      mask_d        = mask_q;
      wdata_d       = wdata_q;
      data_d        = data_q;
      err_d         = err_q;
      cnt_d         = cnt_q;
      if_gnt_o      = 1'b0;
      ls_gnt_o      = 1'b0;
      if_rvalid_o   = 1'b0;
      ls_rvalid_o   = 1'b0;
      if_rdata_o    = '0;
      ls_rdata_o    = '0;
      if_err_o      = 1'b0;
      ls_err_o      = 1'b0;
      mem_req_o     = 1'b0;
      mem_addr_o    = '0;
      mem_wr_mask_o = '0;
      mem_wdata_o   = '0;

      case (state_q)
         ARB_ST_IDLE: begin
            if (if_req_i || ls_req_i) begin
               if (pick_ls) begin
                  ls_gnt_o = 1'b1;
                  owner_d  = ARB_OWN_LS;
                  last_d   = ARB_OWN_LS;
                  addr_d   = ls_addr_i;
                  mask_d   = ls_wr_mask_i;
                  wdata_d  = ls_wdata_i;
               end else begin
                  if_gnt_o = 1'b1;
                  owner_d  = ARB_OWN_IF;
                  last_d   = ARB_OWN_IF;
                  addr_d   = if_addr_i;
                  mask_d   = '0;
                  wdata_d  = '0;
               end
               cnt_d   = '0;
               data_d  = '0;
               err_d   = 1'b0;
               state_d = ARB_ST_ISSUE;
            end
         end
         ARB_ST_ISSUE: begin
            mem_req_o     = 1'b1;
            mem_addr_o    = addr_q;
            mem_wr_mask_o = mask_q;
            mem_wdata_o   = wdata_q;
            // cnt_q counts completed ISSUE cycles, so TIMEOUT-1 marks the last one.
            if (mem_ack_i) begin
               data_d  = mem_rdata_i;
               err_d   = 1'b0;
               state_d = ARB_ST_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = ARB_ST_RESP;
            end
            if (cnt_q != CNT_W'(TIMEOUT)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ARB_ST_RESP: begin
            if (owner_q == ARB_OWN_IF) begin
               if_rvalid_o = 1'b1;
               if_rdata_o  = resp_data;
               if_err_o    = err_q;
            end else begin
               ls_rvalid_o = 1'b1;
               ls_rdata_o  = resp_data;
               ls_err_o    = err_q;
            end
            state_d = ARB_ST_IDLE;
         end
         default: state_d = ARB_ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_rv32im_mem_arbiter.sv
// Directed self-checking bench for rv32im_mem_arbiter.
module tb_rv32im_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid, if_err;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic [31:0] ls_addr;
   logic [3:0]  ls_wr_mask;
   logic [31:0] ls_wdata;
   logic        ls_gnt, ls_rvalid, ls_err;
   logic [31:0] ls_rdata;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wr_mask;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   rv32im_mem_arbiter #(.TIMEOUT(16)) dut (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
      .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
      .ls_req_i(ls_req), .ls_addr_i(ls_addr), .ls_wr_mask_i(ls_wr_mask),
      .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid),
      .ls_rdata_o(ls_rdata), .ls_err_o(ls_err),
      .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_wr_mask_o(mem_wr_mask),
      .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      if_req = 0; if_addr = '0; ls_req = 0; ls_addr = '0; ls_wr_mask = '0;
      ls_wdata = '0; mem_ack = 0; mem_rdata = '0; rst = 1;
      step(); step();
      rst = 0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int unsigned cnt, rv;
      logic        exp_ls;

      // reset state
      do_reset();
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_if_rvalid", if_rvalid, 0);
      check("rst_ls_rvalid", ls_rvalid, 0);
      check("rst_gnts", {if_gnt, ls_gnt}, 0);

      // IFU-only read, ack on first ISSUE cycle
      if_req = 1; if_addr = 32'h10; #1;
      check("if_gnt_T0", if_gnt, 1);
      check("ls_gnt_T0", ls_gnt, 0);
      check("mem_req_T0", mem_req, 0);
      step(); if_req = 0; mem_ack = 1; mem_rdata = 32'hDEADBEEF; #1;
      check("mem_req_T1", mem_req, 1);
      check("mem_addr_T1", mem_addr, 32'h10);
      check("mem_mask_T1", mem_wr_mask, 0);
      check("if_gnt_T1", if_gnt, 0);
      step(); mem_ack = 0; #1;
      check("if_rvalid_T2", if_rvalid, 1);
      check("if_rdata_T2", if_rdata, 32'hDEADBEEF);
      check("if_err_T2", if_err, 0);
      check("ls_rvalid_T2", ls_rvalid, 0);
      check("mem_req_T2", mem_req, 0);
      step();
      check("if_rvalid_T3", if_rvalid, 0);
      check("if_rdata_T3", if_rdata, 0);

      // simultaneous requests from reset: LS, IF, LS, IF
      do_reset();
      if_req = 1; if_addr = 32'h100; ls_req = 1; ls_addr = 32'h200;
      for (int k = 0; k < 4; k++) begin
         exp_ls = (k % 2 == 0);
         #1;
         check("tie_ls_gnt", ls_gnt, exp_ls);
         check("tie_if_gnt", if_gnt, !exp_ls);
         step(); mem_ack = 1; #1;
         check("tie_mem_addr", mem_addr, exp_ls ? 32'h200 : 32'h100);
         step(); mem_ack = 0; #1;
         check("tie_ls_rvalid", ls_rvalid, exp_ls);
         check("tie_if_rvalid", if_rvalid, !exp_ls);
         step();
      end
      if_req = 0; ls_req = 0;

      // LSU store: captured values held through ISSUE, rdata 0
      do_reset();
      ls_req = 1; ls_addr = 32'h3; ls_wr_mask = 4'b1000; ls_wdata = 32'hAB; #1;
      check("st_gnt", ls_gnt, 1);
      step();
      ls_req = 0; ls_addr = 32'h7; ls_wr_mask = 4'b0000; ls_wdata = 32'hFFFFFFFF;
      mem_rdata = 32'h12345678;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("st_mask", mem_wr_mask, 4'b1000);
         check("st_wdata", mem_wdata, 32'hAB);
         check("st_addr", mem_addr, 32'h3);
         step();
      end
      mem_ack = 1; #1;
      check("st_req_at_ack", mem_req, 1);
      step(); mem_ack = 0; #1;
      check("st_rvalid", ls_rvalid, 1);
      check("st_rdata", ls_rdata, 0);
      check("st_err", ls_err, 0);
      step();

      // timeout: 16 ISSUE cycles without ack
      ls_req = 1; ls_addr = 32'h5; ls_wr_mask = 4'b0000; mem_rdata = 32'h55AA55AA; #1;
      step(); ls_req = 0;
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         #1;
         if (mem_req) cnt++;
         step();
      end
      check("to_issue_cycles", cnt, 16);
      check("to_rvalid", ls_rvalid, 1);
      check("to_err", ls_err, 1);
      check("to_rdata", ls_rdata, 0);
      check("to_mem_req", mem_req, 0);
      step();
      check("to_rvalid_after", ls_rvalid, 0);

      // ack on the 16th ISSUE cycle wins over timeout
      ls_req = 1; #1;
      step(); ls_req = 0;
      for (int i = 0; i < 15; i++) step();
      mem_ack = 1; mem_rdata = 32'hCAFEF00D; #1;
      check("ack16_mem_req", mem_req, 1);
      step(); mem_ack = 0; #1;
      check("ack16_rvalid", ls_rvalid, 1);
      check("ack16_err", ls_err, 0);
      check("ack16_rdata", ls_rdata, 32'hCAFEF00D);
      step();

      // reset during ISSUE aborts without rvalid
      if_req = 1; if_addr = 32'h20; #1;
      step(); if_req = 0; #1;
      check("abort_in_issue", mem_req, 1);
      rst = 1; mem_ack = 1;
      step(); rst = 0; mem_ack = 0; #1;
      check("abort_mem_req", mem_req, 0);
      check("abort_mem_addr", mem_addr, 0);
      rv = 0;
      for (int i = 0; i < 10; i++) begin
         if (if_rvalid || ls_rvalid) rv++;
         step();
      end
      check("abort_no_rvalid", rv, 0);

      // spurious ack in IDLE
      mem_ack = 1; mem_rdata = 32'h11111111;
      rv = 0; cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (if_rvalid || ls_rvalid) rv++;
         if (mem_req) cnt++;
      end
      mem_ack = 0;
      check("spur_no_rvalid", rv, 0);
      check("spur_no_mem_req", cnt, 0);
      ls_req = 1; ls_addr = 32'h44; #1;
      check("spur_still_idle", ls_gnt, 1);
      step(); ls_req = 0; mem_ack = 1; mem_rdata = 32'h0BADF00D;
      step(); mem_ack = 0; #1;
      check("spur_then_rvalid", ls_rvalid, 1);
      check("spur_then_rdata", ls_rdata, 32'h0BADF00D);
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
